mul_share_arb: RTL and testbench

- Arbitrates the shared pair of 27x27 multipliers (mul0 lane 0/1) between two requesters. Each requester issues one operand-pair transaction per cycle.
- Supports a lock so a requester can own the unit for a multi-cycle partial-product sequence, such as a 53x53 mantissa product.
- Tracks in-flight ownership through the fixed multiplier latency, then steers each result back to the requester that issued it.
- Sits between the fmad sequencers and the mul0 instances, replacing the combinational en-priority mux.

---
 rtl/fma_pkg.sv | 35 +++
 rtl/mul_tag_pipe.sv | 31 +++
 rtl/mul_share_arb.sv | 159 +++++++++++++++
 tb/tb_mul_share_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
//   MUL_W / PROD_W : operand and product widths of one mul0 lane
//   mulit_t        : operand bundle for both lanes
//   mulot_t        : product bundle for both lanes
//   arb_state_e    : arbiter ownership state
//   tag_t          : in-flight ownership tag {valid, requester id}
package fma_pkg;

  localparam int unsigned MUL_W  = 27;
  localparam int unsigned PROD_W = 54;

  typedef struct packed {
    logic [MUL_W-1:0] a0;
    logic [MUL_W-1:0] b0;
    logic [MUL_W-1:0] a1;
    logic [MUL_W-1:0] b1;
  } mulit_t;

  typedef struct packed {
    logic [PROD_W-1:0] p0;
    logic [PROD_W-1:0] p1;
  } mulot_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic v;
    logic id;
  } tag_t;

endpackage

// File: rtl/mul_tag_pipe.sv
// Ownership tag delay line matching the fixed multiplier latency.
//   clk     : clock
//   clr_n   : synchronous active-low clear of every stage
//   tag_in  : {issue, granted id} captured each cycle
//   tag_out : tag of the issue made MUL_LAT cycles ago
module mul_tag_pipe
  import fma_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t pipe [MUL_LAT];

  // Free-running shift; no stall path exists on the multipliers.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int unsigned i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[MUL_LAT-1];

endmodule

// File: rtl/mul_share_arb.sv
// Arbiter sharing the mul0 lane 0/1 multiplier pair between two requesters,
// with lock support for multi-cycle partial-product sequences and result
// steering through the fixed multiplier latency.
//   clk, reset              : clock, synchronous active-low reset
//   rN_valid/lock/ready     : requester handshake (ready is combinational)
//   rN_a0/b0/a1/b1          : requester operands
//   rN_rvalid, rN_p0/p1     : result return (products broadcast to both)
//   m_en, m_a0/b0/a1/b1     : issue to the multipliers
//   m_p0/p1                 : multiplier products
//   lock_timeout            : pulse in the forced-release cycle
module mul_share_arb
  import fma_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned LOCK_TO = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic              r0_lock,
  output logic              r0_ready,
  input  logic [MUL_W-1:0]  r0_a0,
  input  logic [MUL_W-1:0]  r0_b0,
  input  logic [MUL_W-1:0]  r0_a1,
  input  logic [MUL_W-1:0]  r0_b1,
  output logic              r0_rvalid,
  output logic [PROD_W-1:0] r0_p0,
  output logic [PROD_W-1:0] r0_p1,
  input  logic              r1_valid,
  input  logic              r1_lock,
  output logic              r1_ready,
  input  logic [MUL_W-1:0]  r1_a0,
  input  logic [MUL_W-1:0]  r1_b0,
  input  logic [MUL_W-1:0]  r1_a1,
  input  logic [MUL_W-1:0]  r1_b1,
  output logic              r1_rvalid,
  output logic [PROD_W-1:0] r1_p0,
  output logic [PROD_W-1:0] r1_p1,
  output logic              m_en,
  output logic [MUL_W-1:0]  m_a0,
  output logic [MUL_W-1:0]  m_b0,
  output logic [MUL_W-1:0]  m_a1,
  output logic [MUL_W-1:0]  m_b1,
  input  logic [PROD_W-1:0] m_p0,
  input  logic [PROD_W-1:0] m_p1,
  output logic              lock_timeout
);

  localparam int unsigned CNT_W = $clog2(LOCK_TO + 1);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rr_last, rr_nxt;
  logic             timeout_q, timeout_nxt;
  logic             gnt0, gnt1, issue, gnt_id, lock_sel;
  mulit_t           req0, req1, m_ops;
  mulot_t           res;
  tag_t             tag_in, tag_out;

  assign req0 = {r0_a0, r0_b0, r0_a1, r0_b1};
  assign req1 = {r1_a0, r1_b0, r1_a1, r1_b1};

  // State register; timeout_q is high exactly in the forced-release cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_last   <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rr_last   <= rr_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // Grant and operand mux; the release cycle blocks the owner as well.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (r0_valid && (!r1_valid || rr_last)) gnt0 = 1'b1;
          else if (r1_valid)                      gnt1 = 1'b1;
        end
        OWN0:    gnt0 = r0_valid && !timeout_q;
        OWN1:    gnt1 = r1_valid && !timeout_q;
        default: ;
      endcase
    end
    issue    = gnt0 | gnt1;
    gnt_id   = gnt1;
    lock_sel = gnt1 ? r1_lock : r0_lock;
    m_ops    = gnt0 ? req0 : (gnt1 ? req1 : '0);
  end

  // Next-state: ownership, round-robin pointer and idle counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rr_nxt    = rr_last;
    case (state)
      IDLE: begin
        if (issue) begin
          rr_nxt  = gnt_id;
          cnt_nxt = '0;
          if (lock_sel) state_nxt = gnt_id ? OWN1 : OWN0;
        end
      end
      OWN0, OWN1: begin
        if (timeout_q) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (issue) begin
          rr_nxt  = gnt_id;
          cnt_nxt = '0;
          if (!lock_sel) state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    timeout_nxt = (state_nxt != IDLE) && (cnt_nxt == CNT_W'(LOCK_TO));
  end

  assign tag_in = {issue, gnt_id};

  mul_tag_pipe #(
    .MUL_LAT (MUL_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .clr_n   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign r0_ready     = gnt0;
  assign r1_ready     = gnt1;
  assign m_en         = issue;
  assign m_a0         = m_ops.a0;
  assign m_b0         = m_ops.b0;
  assign m_a1         = m_ops.a1;
  assign m_b1         = m_ops.b1;
  assign lock_timeout = reset & timeout_q;

  // Registered state lingers during the reset cycle, so gate it.
  assign r0_rvalid = reset & tag_out.v & ~tag_out.id;
  assign r1_rvalid = reset & tag_out.v & tag_out.id;

  assign res   = {m_p0, m_p1};
  assign r0_p0 = res.p0;
  assign r0_p1 = res.p1;
  assign r1_p0 = res.p0;
  assign r1_p1 = res.p1;

endmodule

// File: tb/tb_mul_share_arb.sv
module tb_mul_share_arb;
  import fma_pkg::*;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned LOCK_TO = 15;

  logic              clk, reset;
  logic              r0_valid, r0_lock, r0_ready, r0_rvalid;
  logic              r1_valid, r1_lock, r1_ready, r1_rvalid;
  logic [MUL_W-1:0]  r0_a0, r0_b0, r0_a1, r0_b1;
  logic [MUL_W-1:0]  r1_a0, r1_b0, r1_a1, r1_b1;
  logic [PROD_W-1:0] r0_p0, r0_p1, r1_p0, r1_p1;
  logic              m_en, lock_timeout;
  logic [MUL_W-1:0]  m_a0, m_b0, m_a1, m_b1;
  logic [PROD_W-1:0] m_p0, m_p1;

  typedef struct {
    logic              id;
    logic [PROD_W-1:0] p0;
    logic [PROD_W-1:0] p1;
    int                due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic m_rr;

  mul_share_arb #(.MUL_LAT(MUL_LAT), .LOCK_TO(LOCK_TO)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_lock(r0_lock), .r0_ready(r0_ready),
    .r0_a0(r0_a0), .r0_b0(r0_b0), .r0_a1(r0_a1), .r0_b1(r0_b1),
    .r0_rvalid(r0_rvalid), .r0_p0(r0_p0), .r0_p1(r0_p1),
    .r1_valid(r1_valid), .r1_lock(r1_lock), .r1_ready(r1_ready),
    .r1_a0(r1_a0), .r1_b0(r1_b0), .r1_a1(r1_a1), .r1_b1(r1_b1),
    .r1_rvalid(r1_rvalid), .r1_p0(r1_p0), .r1_p1(r1_p1),
    .m_en(m_en), .m_a0(m_a0), .m_b0(m_b0), .m_a1(m_a1), .m_b1(m_b1),
    .m_p0(m_p0), .m_p1(m_p1), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  // Multiplier model: fixed MUL_LAT-cycle registered product.
  logic [PROD_W-1:0] p0_s [MUL_LAT];
  logic [PROD_W-1:0] p1_s [MUL_LAT];
  always @(posedge clk) begin
    p0_s[0] <= 54'(m_a0) * 54'(m_b0);
    p1_s[0] <= 54'(m_a1) * 54'(m_b1);
    for (int i = 1; i < int'(MUL_LAT); i++) begin
      p0_s[i] <= p0_s[i-1];
      p1_s[i] <= p1_s[i-1];
    end
  end
  assign m_p0 = p0_s[MUL_LAT-1];
  assign m_p1 = p1_s[MUL_LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set(input logic v0, input logic l0, input logic v1, input logic l1);
    r0_valid = v0; r0_lock = l0;
    r1_valid = v1; r1_lock = l1;
  endtask

  task automatic rnd_ops();
    r0_a0 = 27'($urandom); r0_b0 = 27'($urandom);
    r0_a1 = 27'($urandom); r0_b1 = 27'($urandom);
    r1_a0 = 27'($urandom); r1_b0 = 27'($urandom);
    r1_a1 = 27'($urandom); r1_b1 = 27'($urandom);
  endtask

  // One clock: check grants/issue at negedge, push/pop scoreboard, advance.
  task automatic step(input logic eg0, input logic eg1, input logic eto);
    logic             is0, is1, erv0, erv1;
    logic [MUL_W-1:0] ea0, eb0, ea1, eb1;
    exp_t             e;
    @(negedge clk);
    chk("r0_ready", r0_ready, eg0);
    chk("r1_ready", r1_ready, eg1);
    chk("lock_timeout", lock_timeout, eto);
    is0 = r0_valid & eg0;
    is1 = r1_valid & eg1;
    chk("m_en", m_en, is0 | is1);
    if (is0 | is1) begin
      ea0 = is1 ? r1_a0 : r0_a0;
      eb0 = is1 ? r1_b0 : r0_b0;
      ea1 = is1 ? r1_a1 : r0_a1;
      eb1 = is1 ? r1_b1 : r0_b1;
      chk("m_a0", m_a0, ea0);
      chk("m_b0", m_b0, eb0);
      chk("m_a1", m_a1, ea1);
      chk("m_b1", m_b1, eb1);
      e.id  = is1;
      e.p0  = 54'(ea0) * 54'(eb0);
      e.p1  = 54'(ea1) * 54'(eb1);
      e.due = cyc + int'(MUL_LAT);
      sb.push_back(e);
    end else begin
      chk("m_a0_idle", m_a0, 0);
    end
    erv0 = 1'b0;
    erv1 = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.id) begin
        erv1 = 1'b1;
        chk("r1_p0", r1_p0, e.p0);
        chk("r1_p1", r1_p1, e.p1);
      end else begin
        erv0 = 1'b1;
        chk("r0_p0", r0_p0, e.p0);
        chk("r0_p1", r0_p1, e.p1);
      end
    end
    chk("r0_rvalid", r0_rvalid, erv0);
    chk("r1_rvalid", r1_rvalid, erv1);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    set(0, 0, 0, 0);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    sb.delete();
    step(0, 0, 0);
    reset = 1'b1;
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b0;
    set(0, 0, 0, 0);
    rnd_ops();
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 1'b1;

    // Single issue with known products
    r0_a0 = 27'd3; r0_b0 = 27'd5; r0_a1 = 27'd7; r0_b1 = 27'd9;
    set(1, 0, 0, 0);
    step(1, 0, 0);
    drain(3);

    // Contention after reset: strict alternation starting at r0
    apply_reset();
    set(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      rnd_ops();
      step(i % 2 == 0, i % 2 == 1, 0);
    end
    drain(3);

    // Lock sequence: r1 locked out for four cycles
    for (int i = 0; i < 4; i++) begin
      rnd_ops();
      set(1, i < 3, 1, 0);
      step(1, 0, 0);
    end
    rnd_ops();
    set(0, 0, 1, 0);
    step(0, 1, 0);
    drain(3);

    // Lock timeout; owner re-asserting in the release cycle loses
    rnd_ops();
    set(1, 1, 0, 0);
    step(1, 0, 0);
    set(0, 0, 1, 0);
    repeat (LOCK_TO) step(0, 0, 0);
    set(1, 0, 1, 0);
    step(0, 0, 1);
    step(0, 1, 0);
    drain(3);

    // Reset mid-flight: in-flight r1 result is dropped
    rnd_ops();
    set(0, 0, 1, 0);
    step(0, 1, 0);
    reset = 1'b0;
    sb.delete();
    set(1, 0, 1, 0);
    step(0, 0, 0);
    reset = 1'b1;
    step(1, 0, 0);
    drain(3);

    // Max-width operands
    r0_a0 = '1; r0_b0 = '1; r0_a1 = '1; r0_b1 = '1;
    set(1, 0, 0, 0);
    step(1, 0, 0);
    drain(3);

    // Random unlocked traffic against a round-robin reference
    m_rr = 1'b0;
    for (int i = 0; i < 24; i++) begin
      logic v0, v1, eg0, eg1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      eg0 = v0 && (!v1 || m_rr);
      eg1 = v1 && !eg0;
      if (eg0) m_rr = 1'b0;
      if (eg1) m_rr = 1'b1;
      rnd_ops();
      set(v0, 0, v1, 0);
      step(eg0, eg1, 0);
    end
    drain(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
